// File: rtl/pmem_scheduler.sv
// rtl/pmem_scheduler.sv - shares the cacheline-adaptor port between I-cache, D-cache and I-prefetcher
// Optional: define PMEM_PF_COALESCE_EN to let an I-cache miss piggyback on an in-flight prefetch of the same line.
module pmem_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_read,
    input  logic [31:0]  ic_address,
    output logic [255:0] ic_rdata,
    output logic         ic_resp,
    input  logic         dc_read,
    input  logic         dc_write,
    input  logic [31:0]  dc_address,
    input  logic [255:0] dc_wdata,
    output logic [255:0] dc_rdata,
    output logic         dc_resp,
    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, GNT_IC, GNT_DR, GNT_DW, GNT_PF} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] age_cnt, age_cnt_next;
    logic [31:0]      grant_address;
    logic             launch;
    logic             done;
    logic             coalesce_hit;

`ifdef PMEM_PF_COALESCE_EN
    // mem_address holds the prefetch line for the whole GNT_PF tenure
    assign coalesce_hit = (state == GNT_PF) && ic_read &&
                          (ic_address[31:5] == mem_address[31:5]);
`else
    assign coalesce_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ic_read && (age_cnt == AGE_MAX)) state_next = GNT_IC;
                else if (dc_write)                   state_next = GNT_DW;
                else if (dc_read)                    state_next = GNT_DR;
                else if (ic_read)                    state_next = GNT_IC;
                else if (pf_read)                    state_next = GNT_PF;
            end
            default: begin
                if (mem_resp) state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_address = 32'h0;
        case (state_next)
            GNT_IC:         grant_address = ic_address;
            GNT_DR, GNT_DW: grant_address = dc_address;
            GNT_PF:         grant_address = pf_address;
            default:        grant_address = 32'h0;
        endcase
    end

    assign launch = (state == IDLE) && (state_next != IDLE);
    assign done   = (state != IDLE) && mem_resp;

    // Aging only tracks D grants taken while an I-fetch is actually waiting
    always_comb begin
        age_cnt_next = age_cnt;
        if (!ic_read)
            age_cnt_next = '0;
        else if (launch && (state_next == GNT_IC))
            age_cnt_next = '0;
        else if (launch && ((state_next == GNT_DR) || (state_next == GNT_DW)) && (age_cnt < AGE_MAX))
            age_cnt_next = age_cnt + CNT_W'(1);
        else if (coalesce_hit && mem_resp)
            age_cnt_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            age_cnt     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 32'h0;
            mem_wdata   <= '0;
        end else begin
            state   <= state_next;
            age_cnt <= age_cnt_next;
            if (launch) begin
                mem_read    <= (state_next != GNT_DW);
                mem_write   <= (state_next == GNT_DW);
                mem_address <= grant_address & 32'hFFFF_FFE0;
                mem_wdata   <= (state_next == GNT_DW) ? dc_wdata : '0;
            end else if (done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

    assign ic_resp = mem_resp && ((state == GNT_IC) || coalesce_hit);
    assign dc_resp = mem_resp && ((state == GNT_DR) || (state == GNT_DW));
    assign pf_resp = mem_resp && (state == GNT_PF);

    assign ic_rdata = ic_resp ? mem_rdata : '0;
    assign dc_rdata = dc_resp ? mem_rdata : '0;
    assign pf_rdata = pf_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_pmem_scheduler.sv
// tb/tb_pmem_scheduler.sv - scoreboard bench for pmem_scheduler with a transaction-level arbitration model
module tb_pmem_scheduler;

    localparam int STARVE = 4;
    localparam int K_IC = 0, K_DR = 1, K_DW = 2, K_PF = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_read, dc_read, dc_write, pf_read;
    logic [31:0]  ic_address, dc_address, pf_address, mem_address;
    logic [255:0] ic_rdata, dc_rdata, pf_rdata, dc_wdata, mem_wdata, mem_rdata;
    logic         ic_resp, dc_resp, pf_resp, mem_read, mem_write, mem_resp;

    pmem_scheduler dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_address(ic_address), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
        .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_resp(dc_resp),
        .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic wr; logic both; logic [255:0] wdata; } dreq_t;
    typedef struct { int kind; logic [31:0] addr; logic [255:0] wdata; logic coal; } txn_t;

    logic [31:0] ic_q[$];
    logic [31:0] pf_q[$];
    dreq_t       dc_q[$];
    txn_t        exp_q[$];

    int n_cmp = 0, n_fail = 0;
    bit ic_en = 1'b1, dc_en = 1'b1, late_pending = 1'b0, mon_en = 1'b0;
    int lat_cnt = 0, fixed_lat = -1, batch_cyc = -100;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        logic [31:0]  base;
        base = a & 32'hFFFF_FFE0;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = (base ^ 32'h5A5A_C3C3) + 32'(k) * 32'h0101_0101;
        return d;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic dreq_t rnd_dreq();
        dreq_t r;
        r.addr  = $urandom;
        r.wr    = 1'($urandom_range(0, 1));
        r.both  = r.wr && ($urandom_range(0, 1) == 1);
        r.wdata = rnd256();
        return r;
    endfunction

    function automatic int next_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 9));
    endfunction

    // Order of service derived straight from the priority/aging rules, one grant at a time
    function automatic void build_model(input bit first_pf);
        int ii = 0, di = 0, pi = 0, age = 0;
        bit ic_p, dc_p, fpf;
        txn_t t;
        fpf = first_pf;
        while (ii < ic_q.size() || di < dc_q.size() || pi < pf_q.size()) begin
            ic_p = ii < ic_q.size();
            dc_p = di < dc_q.size();
            t.coal = 1'b0;
            t.wdata = '0;
            if (fpf)                         t.kind = K_PF;
            else if (ic_p && age == STARVE)  t.kind = K_IC;
            else if (dc_p)                   t.kind = dc_q[di].wr ? K_DW : K_DR;
            else if (ic_p)                   t.kind = K_IC;
            else                             t.kind = K_PF;
            fpf = 1'b0;
            if (t.kind == K_IC) begin
                t.addr = ic_q[ii]; ii++; age = 0;
            end else if (t.kind == K_PF) begin
                t.addr = pf_q[pi];
`ifdef PMEM_PF_COALESCE_EN
                if (ic_p && ic_q[ii][31:5] == pf_q[pi][31:5]) begin
                    t.coal = 1'b1; ii++; age = 0;
                end
`endif
                pi++;
            end else begin
                t.addr = dc_q[di].addr; t.wdata = dc_q[di].wdata; di++;
                if (ic_p && age < STARVE) age++;
            end
            if (!ic_p) age = 0;
            exp_q.push_back(t);
        end
    endfunction

    task automatic drive();
        ic_read = 1'b0; ic_address = 32'h0;
        dc_read = 1'b0; dc_write = 1'b0; dc_address = 32'h0;
        pf_read = 1'b0; pf_address = 32'h0;
        if (ic_en && ic_q.size() > 0) begin ic_read = 1'b1; ic_address = ic_q[0]; end
        if (dc_en && dc_q.size() > 0) begin
            dc_write = dc_q[0].wr; dc_read = !dc_q[0].wr || dc_q[0].both;
            dc_address = dc_q[0].addr; dc_wdata = dc_q[0].wdata;
        end
        if (pf_q.size() > 0) begin pf_read = 1'b1; pf_address = pf_q[0]; end
    endtask

    task automatic step();
        logic ig, dg, pg;
        @(negedge clk);
        ig = ic_resp; dg = dc_resp; pg = pf_resp;
        @(posedge clk); #1;
        if (ig && ic_q.size() > 0) void'(ic_q.pop_front());
        if (dg && dc_q.size() > 0) void'(dc_q.pop_front());
        if (pg && pf_q.size() > 0) void'(pf_q.pop_front());
        mem_resp = 1'b0;
        if (mem_read || mem_write) begin
            if (lat_cnt <= 0) begin
                mem_resp = 1'b1; mem_rdata = line_data(mem_address); lat_cnt = next_lat();
            end else lat_cnt--;
        end else if ($urandom_range(0, 5) == 0) begin
            mem_resp = 1'b1; mem_rdata = rnd256();
        end
        if (late_pending && cyc >= batch_cyc + 2) begin
            ic_en = 1'b1; dc_en = 1'b1; late_pending = 1'b0;
        end
        drive();
    endtask

    task automatic run_batch(input bit late, input int flat);
        int n = 0;
        fixed_lat = flat;
        build_model(late);
        lat_cnt = late ? 3 + int'($urandom_range(0, 5)) : next_lat();
        ic_en = !late; dc_en = !late; late_pending = late;
        batch_cyc = cyc;
        drive();
        while ((ic_q.size() > 0 || dc_q.size() > 0 || pf_q.size() > 0 || exp_q.size() > 0 || late_pending) && n < 600) begin
            step(); n++;
        end
        if (n >= 600) begin
            n_cmp++; n_fail++;
            $display("FAIL batch_timeout: got %0d outstanding expected 0", exp_q.size() + ic_q.size() + dc_q.size() + pf_q.size());
            ic_q.delete(); dc_q.delete(); pf_q.delete(); exp_q.delete(); late_pending = 1'b0;
        end
        ic_en = 1'b1; dc_en = 1'b1; fixed_lat = -1;
        repeat (3) step();
    endtask

    task automatic random_batch();
        int t = int'($urandom_range(0, 2));
        int nic, ndc, npf;
        logic [31:0] pa;
        if (t == 2) begin
            pa = $urandom;
            pf_q.push_back(pa);
            if ($urandom_range(0, 1) == 1) ic_q.push_back({pa[31:5], 5'($urandom)});
            else if ($urandom_range(0, 1) == 1) ic_q.push_back($urandom);
            ndc = int'($urandom_range(0, 2));
            for (int k = 0; k < ndc; k++) dc_q.push_back(rnd_dreq());
            run_batch(1'b1, -1);
        end else begin
            nic = (t == 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            ndc = (t == 1) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 5));
            npf = (t == 0) ? int'($urandom_range(0, 2)) : 0;
            if (nic + ndc + npf == 0) npf = 1;
            for (int k = 0; k < nic; k++) ic_q.push_back($urandom);
            for (int k = 0; k < ndc; k++) dc_q.push_back(rnd_dreq());
            for (int k = 0; k < npf; k++) pf_q.push_back($urandom);
            run_batch(1'b0, -1);
        end
    endtask

    initial begin : monitor
        logic strobe;
        logic [2:0] exp_r;
        bit active = 1'b0;
        txn_t cur;
        int last_resp = -100, exp_start;
        logic h_rd, h_wr;
        logic [31:0] h_addr;
        logic [255:0] h_wd;
        cur.kind = -1; cur.addr = '0; cur.wdata = '0; cur.coal = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                strobe = mem_read | mem_write;
                if (strobe && !active) begin
                    exp_start = (last_resp + 2 > batch_cyc + 1) ? last_resp + 2 : batch_cyc + 1;
                    check("start_cycle", 256'(cyc), 256'(exp_start));
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_txn: got address %0h expected no transaction", mem_address);
                        cur.kind = -1; cur.coal = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("txn_rd_wr", 256'({mem_read, mem_write}), 256'((cur.kind == K_DW) ? 2'b01 : 2'b10));
                        check("txn_address", 256'(mem_address), 256'(cur.addr & 32'hFFFF_FFE0));
                        if (cur.kind == K_DW) check("txn_wdata", mem_wdata, cur.wdata);
                    end
                    active = 1'b1;
                    h_rd = mem_read; h_wr = mem_write; h_addr = mem_address; h_wd = mem_wdata;
                end else if (strobe) begin
                    check("hold_ctrl", 256'({mem_read, mem_write, mem_address}), 256'({h_rd, h_wr, h_addr}));
                    check("hold_wdata", mem_wdata, h_wd);
                end else if (active) begin
                    n_cmp++; n_fail++;
                    $display("FAIL strobe_dropped: got strobe 0 expected 1 until mem_resp");
                    active = 1'b0;
                end
                exp_r = 3'b000;
                if (active && strobe && mem_resp)
                    exp_r = {cur.kind == K_IC || cur.coal, cur.kind == K_DR || cur.kind == K_DW, cur.kind == K_PF};
                check("resp_vec", 256'({ic_resp, dc_resp, pf_resp}), 256'(exp_r));
                if (exp_r[2]) check("ic_rdata", ic_rdata, line_data(cur.addr));
                if (exp_r[1]) check("dc_rdata", dc_rdata, line_data(cur.addr));
                if (exp_r[0]) check("pf_rdata", pf_rdata, line_data(cur.addr));
                if (active && strobe && mem_resp) begin
                    active = 1'b0; last_resp = cyc;
                end
            end
        end
    end

    initial begin : stimulus
        logic [255:0] wd, rd;
        dreq_t d;
        rst = 1'b1;
        ic_read = 1'b0; ic_address = '0; dc_read = 1'b0; dc_write = 1'b0; dc_address = '0; dc_wdata = '0;
        pf_read = 1'b0; pf_address = '0; mem_rdata = '0; mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 256'({mem_read, mem_write, ic_resp, dc_resp, pf_resp, mem_address}), 256'(0));
        check("reset_wdata", mem_wdata, 256'(0));

        rst = 1'b0;
        wd = rnd256();
        dc_write = 1'b1; dc_read = 1'b1; dc_address = 32'h1234_567F; dc_wdata = wd;
        @(posedge clk); #1;
        check("both_rw_strobes", 256'({mem_read, mem_write}), 256'(2'b01));
        check("both_rw_address", 256'(mem_address), 256'(32'h1234_5660));
        check("both_rw_wdata", mem_wdata, wd);
        #2 rst = 1'b1;
        #1 check("async_reset_ctrl", 256'({mem_read, mem_write, mem_address}), 256'(0));
        check("async_reset_wdata", mem_wdata, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0; dc_write = 1'b0; dc_address = 32'h0000_0040;
        @(posedge clk); #1;
        check("post_reset_grant", 256'({mem_read, mem_write, mem_address}), 256'({2'b10, 32'h0000_0040}));
        rd = rnd256(); mem_rdata = rd; mem_resp = 1'b1;
        #1 check("post_reset_resp", 256'({ic_resp, dc_resp, pf_resp}), 256'(3'b010));
        check("post_reset_rdata", dc_rdata, rd);
        @(posedge clk); #1;
        mem_resp = 1'b0; dc_read = 1'b0;
        check("post_resp_strobe_drop", 256'({mem_read, mem_write}), 256'(0));
        @(posedge clk); #1;
        mon_en = 1'b1;

        d.addr = 32'h1234_567F; d.wr = 1'b1; d.both = 1'b1; d.wdata = rnd256();
        dc_q.push_back(d);
        run_batch(1'b0, -1);

        ic_q.push_back(32'h0000_0100); pf_q.push_back(32'h0000_0300);
        d.addr = 32'h0000_0200; d.wr = 1'b0; d.both = 1'b0; dc_q.push_back(d);
        run_batch(1'b0, 10);

        ic_q.push_back(32'h0000_0400);
        for (int k = 0; k < 6; k++) dc_q.push_back(rnd_dreq());
        run_batch(1'b0, -1);

        pf_q.push_back(32'h0000_1040);
        d.addr = 32'h0000_1100; d.wr = 1'b0; d.both = 1'b0; dc_q.push_back(d);
        run_batch(1'b1, -1);

        pf_q.push_back(32'h0000_2000); ic_q.push_back(32'h0000_2014);
        run_batch(1'b1, -1);

        for (int b = 0; b < 40; b++) random_batch();

        repeat (5) step();
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
